// File: rtl/clk_int_div_pkg.sv
// Shared types for the clock-division ratio checker.
// FSM state encoding is common to the top and its bench views.
package clk_int_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS
  } state_e;

endpackage

// File: rtl/clk_int_div_meas_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Depth and reset value are parameters.
module sync #(
  parameter int unsigned STAGES     = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] reg_q;
  logic [STAGES-1:0] reg_d;

  always_comb begin
    reg_d = {reg_q[STAGES-2:0], serial_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= {STAGES{ResetValue}};
    end else begin
      reg_q <= reg_d;
    end
  end

  assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/clk_int_div_meas.sv
// Measures period and high time of a slow async signal in clk_i cycles.
// Publishes one entry per rising-to-rising interval and tracks lock.
module clk_int_div_meas
  import clk_int_div_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 sig_i,
  output logic                 meas_valid_o,
  input  logic                 meas_ready_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 locked_o,
  output logic                 overflow_o
);

  localparam int unsigned W  = CNT_WIDTH;
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [W-1:0]  ONE     = W'(1);
  localparam logic [MW-1:0] M_ONE   = MW'(1);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_COUNT);

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
  } meas_t;

  logic   sig_s;
  logic   rise;
  logic   pub;
  logic   prev_q, prev_d;
  logic   en_q, en_d;
  state_e state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  hcnt_q, hcnt_d;
  logic [W-1:0]  last_q, last_d;
  logic [MW-1:0] match_q, match_d;
  logic   valid_q, valid_d;
  meas_t  out_q, out_d;
  logic   ovf_q, ovf_d;
  logic   locked_q, locked_d;

  sync #(
    .STAGES     (SYNC_STAGES),
    .ResetValue (1'b0)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .serial_i (sig_i),
    .serial_o (sig_s)
  );

  assign rise = sig_s & ~prev_q;

  always_comb begin
    prev_d  = sig_s;
    en_d    = en_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    last_d  = last_q;
    match_d = match_q;
    valid_d = valid_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    pub     = 1'b0;

    if (en_i && !en_q) ovf_d = 1'b0;
    if (valid_q && meas_ready_i) valid_d = 1'b0;

    if (!en_i) begin
      state_d = IDLE;
      match_d = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = ONE;
            hcnt_d  = ONE;
            state_d = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            pub    = 1'b1;
            cnt_d  = ONE;
            hcnt_d = ONE;
          end else if (cnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            match_d = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + ONE;
            if (sig_s) hcnt_d = hcnt_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Lock sees every period; the output slot may still drop it.
    if (pub) begin
      last_d = cnt_q;
      if (match_q == '0 || cnt_q != last_q) begin
        match_d = M_ONE;
      end else if (match_q != LOCK_N) begin
        match_d = match_q + M_ONE;
      end
      if (!valid_q || meas_ready_i) begin
        valid_d      = 1'b1;
        out_d.period = cnt_q;
        out_d.high   = hcnt_q;
      end
    end

    locked_d = (match_d == LOCK_N);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= 1'b0;
      en_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      last_q   <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      en_q     <= en_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      last_q   <= last_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      locked_q <= locked_d;
    end
  end

  assign meas_valid_o = valid_q;
  assign period_o     = out_q.period;
  assign high_o       = out_q.high;
  assign locked_o     = locked_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_clk_int_div_meas.sv
// Randomized bench for clk_int_div_meas with a waveform-level model.
// Two instances: a 16-bit one and a 4-bit one for overflow boundaries.
module tb_clk_int_div_meas;

  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic en1 = 1'b0, sig1 = 1'b0, ready1 = 1'b0;
  logic valid1, locked1, ovf1;
  logic [15:0] period1, high1;

  logic en2 = 1'b0, sig2 = 1'b0, ready2 = 1'b0;
  logic valid2, locked2, ovf2;
  logic [3:0] period2, high2;

  int n_checks = 0;
  int n_fail = 0;

  int exp_p[$];
  int exp_h[$];
  bit exp_l[$];

  logic [15:0] got_p[$];
  logic [15:0] got_h[$];
  logic        got_l[$];
  logic [3:0]  got2_p[$];
  logic [3:0]  got2_h[$];
  int lock_cycles = 0;

  always #5 clk = ~clk;

  clk_int_div_meas #(
    .CNT_WIDTH(16), .LOCK_COUNT(LOCK), .SYNC_STAGES(2)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .sig_i(sig1),
    .meas_valid_o(valid1), .meas_ready_i(ready1),
    .period_o(period1), .high_o(high1),
    .locked_o(locked1), .overflow_o(ovf1)
  );

  clk_int_div_meas #(
    .CNT_WIDTH(4), .LOCK_COUNT(LOCK), .SYNC_STAGES(3)
  ) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .sig_i(sig2),
    .meas_valid_o(valid2), .meas_ready_i(ready2),
    .period_o(period2), .high_o(high2),
    .locked_o(locked2), .overflow_o(ovf2)
  );

  always @(negedge clk) begin
    if (rst_n && valid1 && ready1) begin
      got_p.push_back(period1);
      got_h.push_back(high1);
      got_l.push_back(locked1);
    end
    if (rst_n && valid2 && ready2) begin
      got2_p.push_back(period2);
      got2_h.push_back(high2);
    end
    if (locked1) lock_cycles <= lock_cycles + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit sel, input bit s, input int n);
    if (sel) sig2 = s;
    else sig1 = s;
    repeat (n) tick();
  endtask

  task automatic seg(input bit sel, input int h, input int l);
    drv(sel, 1'b1, h);
    drv(sel, 1'b0, l);
  endtask

  function automatic void model_lock();
    int streak;
    exp_l.delete();
    streak = 0;
    foreach (exp_p[i]) begin
      if (i > 0 && exp_p[i] == exp_p[i-1]) streak++;
      else streak = 1;
      exp_l.push_back(streak >= LOCK);
    end
  endfunction

  // Segments in exp_p/exp_h are driven back to back, then one closing rise.
  task automatic run_segs();
    en1 = 1'b1;
    ready1 = 1'b1;
    drv(1'b0, 1'b0, 5);
    foreach (exp_p[i]) seg(1'b0, exp_h[i], exp_p[i] - exp_h[i]);
    drv(1'b0, 1'b1, 1);
    drv(1'b0, 1'b0, 8);
    model_lock();
  endtask

  task automatic stop1();
    en1 = 1'b0;
    drv(1'b0, 1'b0, 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (valid1 !== 1'b0 || period1 !== 16'd0 || high1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_out: v=%b p=%0d h=%0d want 0", valid1, period1, high1);
    end
    n_checks++;
    if (locked1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: lock=%b ovf=%b want 0", locked1, ovf1);
    end
    n_checks++;
    if (valid2 !== 1'b0 || ovf2 !== 1'b0 || period2 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_dut4: v=%b ovf=%b p=%0d want 0", valid2, ovf2, period2);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_div4();
    int base;
    int n;
    base = got_p.size();
    exp_p.delete();
    exp_h.delete();
    repeat (6) begin
      exp_p.push_back(4);
      exp_h.push_back(2);
    end
    run_segs();
    n = got_p.size() - base;
    n_checks++;
    if (n !== exp_p.size()) begin
      n_fail++;
      $display("FAIL div4_count: got %0d want %0d", n, exp_p.size());
    end
    for (int i = 0; i < n && i < exp_p.size(); i++) begin
      n_checks++;
      if (got_p[base+i] !== 16'(exp_p[i]) || got_h[base+i] !== 16'(exp_h[i])) begin
        n_fail++;
        $display("FAIL div4_data[%0d]: got %0d/%0d want %0d/%0d", i,
                 got_p[base+i], got_h[base+i], exp_p[i], exp_h[i]);
      end
      n_checks++;
      if (got_l[base+i] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL div4_lock[%0d]: got %b want %b", i, got_l[base+i], exp_l[i]);
      end
    end
    stop1();
  endtask

  task automatic test_div5();
    int base;
    int n;
    int h;
    h = $urandom_range(2, 3);
    base = got_p.size();
    exp_p.delete();
    exp_h.delete();
    repeat (6) begin
      exp_p.push_back(5);
      exp_h.push_back(h);
    end
    run_segs();
    n = got_p.size() - base;
    n_checks++;
    if (n !== exp_p.size()) begin
      n_fail++;
      $display("FAIL div5_count: got %0d want %0d", n, exp_p.size());
    end
    for (int i = 0; i < n && i < exp_p.size(); i++) begin
      n_checks++;
      if (got_p[base+i] !== 16'(exp_p[i]) || got_h[base+i] !== 16'(exp_h[i])) begin
        n_fail++;
        $display("FAIL div5_data[%0d]: got %0d/%0d want %0d/%0d", i,
                 got_p[base+i], got_h[base+i], exp_p[i], exp_h[i]);
      end
      n_checks++;
      if (got_l[base+i] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL div5_lock[%0d]: got %b want %b", i, got_l[base+i], exp_l[i]);
      end
    end
    n_checks++;
    if (locked1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div5_locked: got %b want 1", locked1);
    end
    stop1();
  endtask

  task automatic test_alternate();
    int base;
    int n;
    int lc0;
    base = got_p.size();
    lc0 = lock_cycles;
    exp_p.delete();
    exp_h.delete();
    for (int i = 0; i < 8; i++) begin
      exp_p.push_back(i[0] ? 8 : 6);
      exp_h.push_back(i[0] ? 4 : 3);
    end
    run_segs();
    n = got_p.size() - base;
    n_checks++;
    if (n !== exp_p.size()) begin
      n_fail++;
      $display("FAIL alt_count: got %0d want %0d", n, exp_p.size());
    end
    for (int i = 0; i < n && i < exp_p.size(); i++) begin
      n_checks++;
      if (got_p[base+i] !== 16'(exp_p[i]) || got_h[base+i] !== 16'(exp_h[i])) begin
        n_fail++;
        $display("FAIL alt_data[%0d]: got %0d/%0d want %0d/%0d", i,
                 got_p[base+i], got_h[base+i], exp_p[i], exp_h[i]);
      end
    end
    n_checks++;
    if (lock_cycles - lc0 !== 0) begin
      n_fail++;
      $display("FAIL alt_nolock: locked cycles %0d want 0", lock_cycles - lc0);
    end
    stop1();
  endtask

  task automatic test_random();
    int base;
    int n;
    int h;
    int l;
    base = got_p.size();
    exp_p.delete();
    exp_h.delete();
    h = 2;
    l = 2;
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        h = $urandom_range(1, 6);
        l = $urandom_range(1, 6);
      end
      exp_p.push_back(h + l);
      exp_h.push_back(h);
    end
    run_segs();
    n = got_p.size() - base;
    n_checks++;
    if (n !== exp_p.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", n, exp_p.size());
    end
    for (int i = 0; i < n && i < exp_p.size(); i++) begin
      n_checks++;
      if (got_p[base+i] !== 16'(exp_p[i]) || got_h[base+i] !== 16'(exp_h[i])) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %0d/%0d want %0d/%0d", i,
                 got_p[base+i], got_h[base+i], exp_p[i], exp_h[i]);
      end
      n_checks++;
      if (got_l[base+i] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL rand_lock[%0d]: got %b want %b", i, got_l[base+i], exp_l[i]);
      end
    end
    stop1();
  endtask

  task automatic test_backpressure();
    int base;
    int n;
    base = got_p.size();
    en1 = 1'b1;
    ready1 = 1'b0;
    drv(1'b0, 1'b0, 5);
    seg(1'b0, 3, 3);
    for (int i = 0; i < 10; i++) begin
      seg(1'b0, 2, 2);
      if (i >= 2 && i < 7) begin
        n_checks++;
        if (valid1 !== 1'b1 || period1 !== 16'd6 || high1 !== 16'd3) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: v=%b %0d/%0d want 1 6/3", i, valid1, period1, high1);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (locked1 !== 1'b1 || got_p.size() !== base) begin
          n_fail++;
          $display("FAIL bp_lock: lock=%b xfers=%0d want 1 0", locked1, got_p.size() - base);
        end
        ready1 = 1'b1;
      end
    end
    drv(1'b0, 1'b1, 1);
    drv(1'b0, 1'b0, 8);
    n = got_p.size() - base;
    n_checks++;
    if (n < 2 || n > 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 2..6", n);
    end
    if (n > 0) begin
      n_checks++;
      if (got_p[base] !== 16'd6 || got_h[base] !== 16'd3) begin
        n_fail++;
        $display("FAIL bp_first: got %0d/%0d want 6/3", got_p[base], got_h[base]);
      end
    end
    for (int i = 1; i < n; i++) begin
      n_checks++;
      if (got_p[base+i] !== 16'd4 || got_h[base+i] !== 16'd2) begin
        n_fail++;
        $display("FAIL bp_fresh[%0d]: got %0d/%0d want 4/2", i, got_p[base+i], got_h[base+i]);
      end
    end
    stop1();
  endtask

  task automatic test_en_drop();
    int base;
    en1 = 1'b1;
    ready1 = 1'b0;
    drv(1'b0, 1'b0, 5);
    repeat (6) seg(1'b0, 2, 2);
    drv(1'b0, 1'b1, 1);
    n_checks++;
    if (valid1 !== 1'b1 || locked1 !== 1'b1 || period1 !== 16'd4) begin
      n_fail++;
      $display("FAIL endrop_pre: v=%b lock=%b p=%0d want 1 1 4", valid1, locked1, period1);
    end
    en1 = 1'b0;
    tick();
    n_checks++;
    if (valid1 !== 1'b0 || locked1 !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_post: v=%b lock=%b want 0 0", valid1, locked1);
    end
    ready1 = 1'b1;
    drv(1'b0, 1'b0, 2);
    base = got_p.size();
    en1 = 1'b1;
    drv(1'b0, 1'b0, 5);
    seg(1'b0, 2, 2);
    drv(1'b0, 1'b1, 1);
    drv(1'b0, 1'b0, 8);
    n_checks++;
    if (got_p.size() - base !== 1) begin
      n_fail++;
      $display("FAIL endrop_reen: got %0d publishes want 1", got_p.size() - base);
    end else begin
      n_checks++;
      if (got_p[base] !== 16'd4 || got_h[base] !== 16'd2) begin
        n_fail++;
        $display("FAIL endrop_data: got %0d/%0d want 4/2", got_p[base], got_h[base]);
      end
    end
    stop1();
  endtask

  task automatic test_reset_mid();
    int base;
    en1 = 1'b1;
    ready1 = 1'b1;
    drv(1'b0, 1'b0, 5);
    repeat (3) seg(1'b0, 2, 2);
    drv(1'b0, 1'b1, 1);
    n_checks++;
    if (period1 !== 16'd4) begin
      n_fail++;
      $display("FAIL rst_pre: p=%0d want 4", period1);
    end
    rst_n = 1'b0;
    sig1 = 1'b0;
    #1;
    n_checks++;
    if (valid1 !== 1'b0 || locked1 !== 1'b0 || period1 !== 16'd0 || high1 !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async: v=%b lock=%b %0d/%0d want 0", valid1, locked1, period1, high1);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    base = got_p.size();
    drv(1'b0, 1'b0, 5);
    n_checks++;
    if (got_p.size() !== base || valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: xfers=%0d v=%b want 0 0", got_p.size() - base, valid1);
    end
    seg(1'b0, 2, 2);
    drv(1'b0, 1'b1, 1);
    drv(1'b0, 1'b0, 8);
    n_checks++;
    if (got_p.size() - base !== 1) begin
      n_fail++;
      $display("FAIL rst_reen: got %0d publishes want 1", got_p.size() - base);
    end
    stop1();
  endtask

  task automatic test_overflow();
    int base;
    base = got2_p.size();
    ready2 = 1'b1;
    en2 = 1'b1;
    drv(1'b1, 1'b0, 5);
    drv(1'b1, 1'b1, 2);
    drv(1'b1, 1'b0, 14);
    n_checks++;
    if (ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early: ovf=%b want 0", ovf2);
    end
    drv(1'b1, 1'b0, 6);
    n_checks++;
    if (ovf2 !== 1'b1 || got2_p.size() !== base || valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b xfers=%0d v=%b want 1 0 0", ovf2,
               got2_p.size() - base, valid2);
    end
    seg(1'b1, 2, 2);
    seg(1'b1, 2, 2);
    drv(1'b1, 1'b1, 1);
    drv(1'b1, 1'b0, 8);
    n_checks++;
    if (got2_p.size() - base !== 2) begin
      n_fail++;
      $display("FAIL ovf_waitrise: got %0d publishes want 2", got2_p.size() - base);
    end else begin
      n_checks++;
      if (got2_p[base] !== 4'd4 || got2_h[base+1] !== 4'd2) begin
        n_fail++;
        $display("FAIL ovf_after: got %0d/%0d want 4/2", got2_p[base], got2_h[base+1]);
      end
    end
    n_checks++;
    if (ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b want 1", ovf2);
    end
    en2 = 1'b0;
    tick();
    en2 = 1'b1;
    tick();
    n_checks++;
    if (ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b want 0", ovf2);
    end
    base = got2_p.size();
    drv(1'b1, 1'b0, 5);
    seg(1'b1, 1, 14);
    drv(1'b1, 1'b1, 1);
    drv(1'b1, 1'b0, 7);
    n_checks++;
    if (got2_p.size() - base !== 1 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_edge15: publishes=%0d ovf=%b want 1 0", got2_p.size() - base, ovf2);
    end else begin
      n_checks++;
      if (got2_p[base] !== 4'd15 || got2_h[base] !== 4'd1) begin
        n_fail++;
        $display("FAIL ovf_edge15_data: got %0d/%0d want 15/1", got2_p[base], got2_h[base]);
      end
    end
    drv(1'b1, 1'b0, 14);
    n_checks++;
    if (ovf2 !== 1'b1 || got2_p.size() - base !== 1) begin
      n_fail++;
      $display("FAIL ovf_edge16: ovf=%b publishes=%0d want 1 1", ovf2, got2_p.size() - base);
    end
    en2 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div5();
    test_alternate();
    test_random();
    test_backpressure();
    test_en_drop();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
